ga_generation_sequencer: RTL and testbench
==========================================

Name: ga_generation_sequencer

Overview:
- Top-level control FSM for the genetic brew-run engine.
- Sequences initial-population, selection and mutation engines through a run-time programmable number of generations, and holds the current population in a register.
- Hands a final report to the UART transmitter via valid/ready.
- Parametrised successor to the fixed-width, fixed-limit generation controller. Adds pulsed starts, abort, reset, a ready/valid report handshake and optional stagnation early-stop.

Parameters:
POP_W, 7500, population vector width in bits
GEN_W, 16, generation counter and limit width
FIT_W, 16, fitness word width (early-stop compare)
STALL_LIMIT, 8, non-improving generations before early stop (early-stop builds only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  run request, sampled in IDLE only
abort  in  1  abandon current run
gen_limit  in  GEN_W  generations to run, latched when start is accepted
in_pop  in  POP_W  initial population from init engine
mut_pop  in  POP_W  mutated population from mutation engine
in_done  in  1  init engine finished
sel_done  in  1  selection engine finished
mut_done  in  1  mutation engine finished
best_fit  in  FIT_W  best fitness of mut_pop, valid with mut_done
tx_ready  in  1  UART transmitter accepts report
population  out  POP_W  registered current population
in_start  out  1  one-cycle init start pulse
sel_start  out  1  one-cycle selection start pulse
mut_start  out  1  one-cycle mutation start pulse
tx_valid  out  1  report available to UART
busy  out  1  high in every state except IDLE
gen_count  out  GEN_W  completed generations in this run
state_out  out  3  current state encoding

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst_n low at a rising edge forces state IDLE. It also sets to 0: population, gen_count, all *_start outputs, tx_valid, busy, the latched limit and the early-stop registers.
  - Reset mid-run aborts immediately. No report is sent.
- States and encodings: IDLE=0, INIT=1, SEL=2, MUT=3, REPORT=4. Encodings 5–7 are illegal and go to IDLE on the next cycle.
- Start pulses:
  - Each engine start pulse is registered.
  - It is high for exactly the first cycle spent in INIT, SEL or MUT respectively.
  - Every entry into SEL or MUT produces a new pulse.
- Done sampling:
  - Each done input is ignored during the pulse cycle of its own state.
  - It is sampled on every later cycle in that state.
  - Done inputs for other states are ignored.
- IDLE:
  - start=1 moves to INIT, latches gen_limit into lim_r and clears gen_count.
  - start in any other state is ignored.
  - gen_count holds its last value while in IDLE.
- INIT:
  - On accepted in_done, population <= in_pop.
  - Next state is SEL, or REPORT if lim_r==0.
- SEL: on accepted sel_done, go to MUT.
- MUT, on accepted mut_done:
  - population <= mut_pop.
  - gen_count <= gen_count+1.
  - If gen_count+1 == lim_r, go to REPORT; otherwise go to SEL.
  - gen_count saturates at all-ones and never wraps.
- REPORT:
  - tx_valid=1, and population and gen_count are held stable.
  - On tx_valid&&tx_ready, go to IDLE. tx_valid drops in the following cycle.
- Abort:
  - abort=1 in any state other than IDLE goes to IDLE on the next cycle.
  - Abort takes priority over a simultaneous done or tx_ready.
  - population and gen_count hold their values. No report is sent.
  - abort in IDLE has no effect.
- population changes only on accepted in_done or mut_done, or on reset.
- busy is decoded combinationally from the state register.

Optional Feature:
- Macro GA_EARLY_STOP_EN.
- When defined:
  - Registers best_r (FIT_W bits) and stall_r (counts up to STALL_LIMIT) are cleared when start is accepted.
  - On each accepted mut_done, if best_fit > best_r (unsigned compare): best_r <= best_fit and stall_r <= 0.
  - Otherwise stall_r increments. When it reaches STALL_LIMIT, the next state is REPORT even if gen_count+1 < lim_r.
  - The generation-limit exit still applies, whichever condition occurs first.
- When not defined: the best_fit port is present but ignored, no best_r/stall_r logic exists, and the exit is on the generation limit only.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with start=1. Required: state_out=0, population=0, gen_count=0, every output 0.
2. Normal run with gen_limit=3:
   - Stimulus: start, then in_done, then 3 × (sel_done, mut_done). Done inputs return 2 cycles after their start pulse. mut_pop=0xA5… on the last generation; tx_ready is raised 4 cycles into REPORT.
   - Required: in_start ×1, sel_start ×3, mut_start ×3, each pulse exactly 1 cycle.
   - Required: gen_count=3, population=last mut_pop, tx_valid held for 4 cycles, then IDLE with busy=0.
3. gen_limit=0: start, then in_done. Required: INIT→REPORT with no sel_start, population=in_pop, gen_count=0.
4. Abort with simultaneous done, gen_limit=5: in generation 2, raise abort in the same cycle as mut_done. Required: IDLE next cycle, gen_count=1, population unchanged, tx_valid never asserted.
5. Ignored inputs:
   - start while in SEL: no effect.
   - sel_done=1 during the sel_start pulse cycle: not accepted.
   - Stray mut_done while in SEL: ignored.
6. GA_EARLY_STOP_EN build:
   - Stimulus: STALL_LIMIT=2, gen_limit=10, best_fit sequence 5, 7, 7, 6.
   - Required: REPORT after generation 4 with gen_count=4.
   - Required in a non-macro build with the same stimulus: REPORT at gen_count=10.

Source files
------------

// File: rtl/ga_generation_sequencer.sv
// Generation sequencer for the genetic brew-run engine: init -> (sel -> mut)* -> report.
// Optional stagnation early-stop is built when GA_EARLY_STOP_EN is defined.
module ga_generation_sequencer #(
    parameter int POP_W       = 7500,
    parameter int GEN_W       = 16,
    parameter int FIT_W       = 16,
    parameter int STALL_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [GEN_W-1:0] gen_limit,
    input  logic [POP_W-1:0] in_pop,
    input  logic [POP_W-1:0] mut_pop,
    input  logic             in_done,
    input  logic             sel_done,
    input  logic             mut_done,
    input  logic [FIT_W-1:0] best_fit,
    input  logic             tx_ready,
    output logic [POP_W-1:0] population,
    output logic             in_start,
    output logic             sel_start,
    output logic             mut_start,
    output logic             tx_valid,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic [2:0]       state_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] INIT   = 3'd1;
    localparam logic [2:0] SEL    = 3'd2;
    localparam logic [2:0] MUT    = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [GEN_W-1:0] lim_r;
    logic [GEN_W-1:0] gen_inc;
    logic             start_acc;
    logic             in_acc;
    logic             sel_acc;
    logic             mut_acc;
    logic             gen_exit;
    logic             stop_early;

    // Done inputs are masked during the start-pulse cycle of their own state.
    assign start_acc = (state == IDLE) && start;
    assign in_acc    = (state == INIT) && !in_start && in_done;
    assign sel_acc   = (state == SEL) && !sel_start && sel_done;
    assign mut_acc   = (state == MUT) && !mut_start && mut_done;

    assign gen_inc  = (&gen_count) ? gen_count : gen_count + 1'b1;
    assign gen_exit = (gen_inc == lim_r) || stop_early;

`ifdef GA_EARLY_STOP_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [FIT_W-1:0]   best_r;
    logic [STALL_W-1:0] stall_r;
    logic [STALL_W-1:0] stall_inc;
    logic               improve;

    assign improve    = best_fit > best_r;
    assign stall_inc  = stall_r + 1'b1;
    assign stop_early = !improve && (stall_inc >= STALL_W'(STALL_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_r  <= '0;
            stall_r <= '0;
        end else if (start_acc) begin
            best_r  <= '0;
            stall_r <= '0;
        end else if (mut_acc && !abort) begin
            if (improve) begin
                best_r  <= best_fit;
                stall_r <= '0;
            end else begin
                stall_r <= stall_inc;
            end
        end
    end
`else
    logic unused_fit;

    assign unused_fit = ^best_fit;
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_start  <= 1'b0;
            sel_start <= 1'b0;
            mut_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_start  <= (state_nxt == INIT) && (state != INIT);
            sel_start <= (state_nxt == SEL) && (state != SEL);
            mut_start <= (state_nxt == MUT) && (state != MUT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                if (abort) state_nxt = IDLE;
                else if (in_acc) state_nxt = (lim_r == '0) ? REPORT : SEL;
            end
            SEL: begin
                if (abort) state_nxt = IDLE;
                else if (sel_acc) state_nxt = MUT;
            end
            MUT: begin
                if (abort) state_nxt = IDLE;
                else if (mut_acc) state_nxt = gen_exit ? REPORT : SEL;
            end
            REPORT: begin
                if (abort || tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            population <= '0;
            gen_count  <= '0;
            lim_r      <= '0;
        end else begin
            if (start_acc) begin
                lim_r     <= gen_limit;
                gen_count <= '0;
            end
            if (in_acc && !abort) begin
                population <= in_pop;
            end
            if (mut_acc && !abort) begin
                population <= mut_pop;
                gen_count  <= gen_inc;
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        tx_valid  = (state == REPORT);
        state_out = state;
    end

endmodule

// File: tb/tb_ga_generation_sequencer.sv
// Scoreboard bench for ga_generation_sequencer: stimulus queues expected reports,
// a negedge monitor pops them on each report handshake and checks pulse widths.
module tb_ga_generation_sequencer;

    localparam int PW = 64;
    localparam int GW = 16;
    localparam int FW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [GW-1:0] gen_limit;
    logic [PW-1:0] in_pop;
    logic [PW-1:0] mut_pop;
    logic          in_done;
    logic          sel_done;
    logic          mut_done;
    logic [FW-1:0] best_fit;
    logic          tx_ready;
    logic [PW-1:0] population;
    logic          in_start;
    logic          sel_start;
    logic          mut_start;
    logic          tx_valid;
    logic          busy;
    logic [GW-1:0] gen_count;
    logic [2:0]    state_out;

    ga_generation_sequencer #(
        .POP_W(PW), .GEN_W(GW), .FIT_W(FW), .STALL_LIMIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .gen_limit(gen_limit), .in_pop(in_pop), .mut_pop(mut_pop),
        .in_done(in_done), .sel_done(sel_done), .mut_done(mut_done),
        .best_fit(best_fit), .tx_ready(tx_ready), .population(population),
        .in_start(in_start), .sel_start(sel_start), .mut_start(mut_start),
        .tx_valid(tx_valid), .busy(busy), .gen_count(gen_count),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [GW-1:0] gen;
        logic [PW-1:0] pop;
        int            vcyc;
    } rpt_t;

    rpt_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int in_n, sel_n, mut_n, in_w, sel_w, mut_w, vcyc, tv_total;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse widths, report handshakes against the scoreboard.
    initial begin
        rpt_t e;
        in_w = 0; sel_w = 0; mut_w = 0; vcyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_w = 0; sel_w = 0; mut_w = 0; vcyc = 0;
            end else begin
                if (in_start) in_w++;
                else if (in_w != 0) begin
                    check("in_start_width", in_w, 1); in_n++; in_w = 0;
                end
                if (sel_start) sel_w++;
                else if (sel_w != 0) begin
                    check("sel_start_width", sel_w, 1); sel_n++; sel_w = 0;
                end
                if (mut_start) mut_w++;
                else if (mut_w != 0) begin
                    check("mut_start_width", mut_w, 1); mut_n++; mut_w = 0;
                end
                if (tx_valid) begin
                    vcyc++; tv_total++;
                end
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_report: gen_count %0d, none expected",
                                 gen_count);
                    end else begin
                        e = sb.pop_front();
                        check("report_gen_count", gen_count, e.gen);
                        check("report_population", population, e.pop);
                        check("report_valid_cycles", vcyc, e.vcyc);
                    end
                    vcyc = 0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hi(input string name, input int which);
        logic s;
        for (int i = 0; i < 100; i++) begin
            case (which)
                0: s = in_start;
                1: s = sel_start;
                2: s = mut_start;
                default: s = tx_valid;
            endcase
            if (s) return;
            cyc();
        end
        vectors++; miscompares++;
        $display("FAIL %s_timeout: got 0 expected 1 within 100 cycles", name);
    endtask

    task automatic clr_counts();
        in_n = 0; sel_n = 0; mut_n = 0; tv_total = 0;
    endtask

    task automatic do_start(input logic [GW-1:0] lim);
        gen_limit = lim; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_init(input logic [PW-1:0] p);
        wait_hi("in_start", 0);
        cyc(); cyc();
        in_pop = p; in_done = 1'b1;
        cyc();
        in_done = 1'b0;
    endtask

    task automatic do_sel();
        wait_hi("sel_start", 1);
        cyc(); cyc();
        sel_done = 1'b1;
        cyc();
        sel_done = 1'b0;
    endtask

    task automatic do_mut(input logic [PW-1:0] p, input logic [FW-1:0] f,
                          input logic ab);
        wait_hi("mut_start", 2);
        cyc(); cyc();
        mut_pop = p; best_fit = f; mut_done = 1'b1; abort = ab;
        cyc();
        mut_done = 1'b0; abort = 1'b0;
    endtask

    task automatic finish_report(input int hold);
        wait_hi("tx_valid", 3);
        repeat (hold - 1) cyc();
        tx_ready = 1'b1;
        cyc();
        tx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fits[10];
        int n_exp;
        fits = '{5, 7, 7, 6, 6, 6, 6, 6, 6, 6};
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; gen_limit = 16'd7;
        in_pop = '1; mut_pop = '1; in_done = 1'b0; sel_done = 1'b0;
        mut_done = 1'b0; best_fit = '0; tx_ready = 1'b0;
        clr_counts();

        // Reset held with start asserted
        cyc(); cyc();
        check("rst_state", state_out, 0);
        check("rst_population", population, 0);
        check("rst_gen_count", gen_count, 0);
        check("rst_starts", {in_start, sel_start, mut_start}, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1; start = 1'b0;
        cyc();

        // Normal run, three generations
        clr_counts();
        sb.push_back('{gen: 16'd3, pop: 64'hA5A5_A5A5_A5A5_A5A5, vcyc: 4});
        do_start(16'd3);
        check("busy_after_start", busy, 1);
        do_init(64'h0000_0000_0000_1000);
        do_sel(); do_mut(64'h0000_0000_0000_1001, 16'd1, 1'b0);
        do_sel(); do_mut(64'h0000_0000_0000_1002, 16'd2, 1'b0);
        do_sel(); do_mut(64'hA5A5_A5A5_A5A5_A5A5, 16'd3, 1'b0);
        check("run3_state_report", state_out, 4);
        finish_report(4);
        check("run3_idle", state_out, 0);
        check("run3_busy", busy, 0);
        check("run3_tx_valid_drop", tx_valid, 0);
        cyc();
        check("run3_gen_hold", gen_count, 3);
        check("run3_pop_hold", population, 64'hA5A5_A5A5_A5A5_A5A5);
        check("run3_in_pulses", in_n, 1);
        check("run3_sel_pulses", sel_n, 3);
        check("run3_mut_pulses", mut_n, 3);

        // Zero generation limit
        clr_counts();
        sb.push_back('{gen: 16'd0, pop: 64'h0BAD_F00D_0000_0003, vcyc: 1});
        do_start(16'd0);
        do_init(64'h0BAD_F00D_0000_0003);
        check("lim0_report", state_out, 4);
        finish_report(1);
        cyc();
        check("lim0_no_sel", sel_n, 0);

        // Abort together with mut_done in generation 2
        clr_counts();
        do_start(16'd5);
        do_init(64'h0000_0000_0000_2000);
        do_sel(); do_mut(64'h0000_0000_0000_2001, 16'd1, 1'b0);
        do_sel(); do_mut(64'h0000_0000_0000_2002, 16'd2, 1'b1);
        check("abort_idle", state_out, 0);
        check("abort_gen_count", gen_count, 1);
        check("abort_population", population, 64'h0000_0000_0000_2001);
        repeat (4) cyc();
        check("abort_no_tx_valid", tv_total, 0);

        // Ignored inputs while in SEL
        clr_counts();
        sb.push_back('{gen: 16'd2, pop: 64'h0000_0000_0000_3002, vcyc: 1});
        do_start(16'd2);
        do_init(64'h0000_0000_0000_3000);
        wait_hi("sel_start", 1);
        start = 1'b1; sel_done = 1'b1; mut_done = 1'b1;
        mut_pop = 64'hDEAD_DEAD_DEAD_DEAD;
        cyc();
        start = 1'b0; sel_done = 1'b0;
        check("sel_done_in_pulse", state_out, 2);
        cyc();
        mut_done = 1'b0;
        check("stray_mut_done_state", state_out, 2);
        check("stray_mut_done_pop", population, 64'h0000_0000_0000_3000);
        sel_done = 1'b1;
        cyc();
        sel_done = 1'b0;
        check("sel_accepted", state_out, 3);
        do_mut(64'h0000_0000_0000_3001, 16'd1, 1'b0);
        do_sel(); do_mut(64'h0000_0000_0000_3002, 16'd2, 1'b0);
        finish_report(1);
        cyc();
        check("start_in_sel_ignored", in_n, 1);

        // Stagnation run: best_fit 5,7,7,6 then flat
`ifdef GA_EARLY_STOP_EN
        n_exp = 4;
`else
        n_exp = 10;
`endif
        clr_counts();
        sb.push_back('{gen: GW'(n_exp), pop: 64'h4444_0000_0000_0000 + 64'(n_exp),
                       vcyc: 1});
        do_start(16'd10);
        do_init(64'h4444_0000_0000_0000);
        for (int g = 1; g <= n_exp; g++) begin
            do_sel();
            do_mut(64'h4444_0000_0000_0000 + 64'(g), FW'(fits[g-1]), 1'b0);
        end
        check("stall_report_state", state_out, 4);
        finish_report(1);
        repeat (3) cyc();
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
